// File: rtl/e1_crc4_rx_ctrl_pkg.sv
// Shared constants for the E1 CRC-4 receive path: TS0/Si positions, C/E-bit frames,
// CRC-4 polynomial/seed, controller state encodings and the serial CRC step.
package e1_crc4_rx_ctrl_pkg;

    localparam logic [3:0] CRC4_POLY      = 4'h3;
    localparam logic [3:0] CRC4_INIT      = 4'h0;

    localparam logic [4:0] TS0            = 5'd0;
    localparam logic [4:0] TS_LAST        = 5'd31;
    localparam logic [2:0] SI_BITPOS      = 3'd0;
    localparam logic [2:0] BITPOS_LAST    = 3'd7;
    localparam logic [2:0] SMF_LAST_FRAME = 3'd7;
    localparam logic [3:0] E1_FRAME       = 4'd13;
    localparam logic [3:0] E2_FRAME       = 4'd15;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FIRST = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    // One bit of M(x)*x^4 mod G(x); crc[3] is the x^3 coefficient (C1).
    function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[3];
        return {crc[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'h0);
    endfunction

endpackage

// File: rtl/e1_crc4_rx_ctrl_crc4.sv
// Serial CRC-4 engine: in_first restarts the remainder from INIT with the current bit.
module e1_crc4
    import e1_crc4_rx_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_first,
    input  logic       in_bit,
    output logic [3:0] out_crc
);

    logic [3:0] crc_q;
    logic [3:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (in_valid) begin
            crc_d = crc4_step(in_first ? CRC4_INIT : crc_q, in_bit);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= CRC4_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign out_crc = crc_q;

endmodule

// File: rtl/e1_crc4_rx_ctrl.sv
// E1 CRC-4 receive controller: frames SMFs, checks received C bits against the previous
// SMF's CRC, counts CRC/E-bit errors and raises CRC-4 loss over a window of SMFs.
module e1_crc4_rx_ctrl
    import e1_crc4_rx_ctrl_pkg::*;
#(
    parameter int WIN_SMF    = 1000,
    parameter int WIN_THRESH = 915,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic [3:0]       in_frame,
    input  logic [4:0]       in_ts,
    input  logic [2:0]       in_bitpos,
    input  logic             in_mf_sync,
    input  logic             cnt_clr,
    output logic             out_crc_ok,
    output logic             out_crc_err,
    output logic             out_smf,
    output logic             out_ebit_err,
    output logic             out_crc_lost,
    output logic [CNT_W-1:0] out_err_cnt,
    output logic [CNT_W-1:0] out_ebit_cnt
);

    localparam int SMF_W = (WIN_SMF > 1) ? $clog2(WIN_SMF) : 1;
    localparam int WE_W  = $clog2(WIN_SMF + 1);
    localparam logic [SMF_W-1:0] SMF_LAST_V = SMF_W'(WIN_SMF - 1);
    localparam logic [WE_W-1:0]  THRESH_V   = WE_W'(WIN_THRESH);

    logic si, sos, eos, c_pos, e_pos;
    logic [3:0] engine_crc;

    assign si    = in_valid & (in_ts == TS0) & (in_bitpos == SI_BITPOS);
    assign sos   = si & (in_frame[2:0] == 3'd0);
    assign eos   = in_valid & (in_frame[2:0] == SMF_LAST_FRAME) & (in_ts == TS_LAST)
                 & (in_bitpos == BITPOS_LAST);
    assign c_pos = si & ~in_frame[0];
    assign e_pos = si & ((in_frame == E1_FRAME) | (in_frame == E2_FRAME));

    e1_crc4 u_crc4 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_first (sos),
        .in_bit   (in_bit & ~c_pos),
        .out_crc  (engine_crc)
    );

    logic [1:0]       state_q, state_d;
    logic [3:0]       rx_c_q, rx_c_d;
    logic [3:0]       calc_prev_q, calc_prev_d;
    logic             calc_valid_q, calc_valid_d;
    logic             eos_q, eos_d;
    logic             eos_smf_q, eos_smf_d;
    logic [SMF_W-1:0] smf_cnt_q, smf_cnt_d;
    logic [WE_W-1:0]  win_err_q, win_err_d;
    logic             ok_q, ok_d, err_q, err_d, smf_q, smf_d;
    logic             ebit_q, ebit_d, lost_q, lost_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d, ebit_cnt_q, ebit_cnt_d;
    logic             mismatch, crc_inc, e_inc;
    logic [WE_W-1:0]  win_err_sum;

    always_comb begin
        state_d      = state_q;
        rx_c_d       = rx_c_q;
        calc_prev_d  = calc_prev_q;
        calc_valid_d = calc_valid_q;
        eos_d        = 1'b0;
        eos_smf_d    = eos_smf_q;
        smf_cnt_d    = smf_cnt_q;
        win_err_d    = win_err_q;
        ok_d         = 1'b0;
        err_d        = 1'b0;
        smf_d        = smf_q;
        ebit_d       = 1'b0;
        lost_d       = 1'b0;
        mismatch     = 1'b0;
        crc_inc      = 1'b0;
        e_inc        = 1'b0;
        win_err_sum  = win_err_q;

        if (c_pos) begin
            rx_c_d = {rx_c_q[2:0], in_bit};
        end

        if (!in_mf_sync) begin
            state_d      = ST_IDLE;
            calc_valid_d = 1'b0;
            smf_cnt_d    = '0;
            win_err_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE:  if (sos) state_d = ST_FIRST;
                ST_FIRST: if (eos) state_d = ST_RUN;
                default:  ;
            endcase

            eos_d = eos & (state_q != ST_IDLE);
            if (eos) begin
                eos_smf_d = in_frame[3];
            end

            if (e_pos && (state_q != ST_IDLE) && !in_bit) begin
                ebit_d = 1'b1;
                e_inc  = 1'b1;
            end

            // The engine register holds the finished SMF CRC for exactly this one cycle.
            if (eos_q) begin
                if ((state_q == ST_RUN) && calc_valid_q) begin
                    mismatch    = (rx_c_q != calc_prev_q);
                    ok_d        = ~mismatch;
                    err_d       = mismatch;
                    smf_d       = eos_smf_q;
                    crc_inc     = mismatch;
                    win_err_sum = win_err_q + WE_W'(mismatch);
                    if (smf_cnt_q == SMF_LAST_V) begin
                        lost_d    = (win_err_sum >= THRESH_V);
                        smf_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        smf_cnt_d = smf_cnt_q + SMF_W'(1);
                        win_err_d = win_err_sum;
                    end
                end
                calc_prev_d  = engine_crc;
                calc_valid_d = 1'b1;
            end
        end

        err_cnt_d  = err_cnt_q;
        ebit_cnt_d = ebit_cnt_q;
        if (cnt_clr) begin
            err_cnt_d  = crc_inc ? CNT_W'(1) : '0;
            ebit_cnt_d = e_inc ? CNT_W'(1) : '0;
        end else begin
            if (crc_inc && !(&err_cnt_q))  err_cnt_d  = err_cnt_q + CNT_W'(1);
            if (e_inc && !(&ebit_cnt_q))   ebit_cnt_d = ebit_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rx_c_q       <= '0;
            calc_prev_q  <= '0;
            calc_valid_q <= 1'b0;
            eos_q        <= 1'b0;
            eos_smf_q    <= 1'b0;
            smf_cnt_q    <= '0;
            win_err_q    <= '0;
            ok_q         <= 1'b0;
            err_q        <= 1'b0;
            smf_q        <= 1'b0;
            ebit_q       <= 1'b0;
            lost_q       <= 1'b0;
            err_cnt_q    <= '0;
            ebit_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            rx_c_q       <= rx_c_d;
            calc_prev_q  <= calc_prev_d;
            calc_valid_q <= calc_valid_d;
            eos_q        <= eos_d;
            eos_smf_q    <= eos_smf_d;
            smf_cnt_q    <= smf_cnt_d;
            win_err_q    <= win_err_d;
            ok_q         <= ok_d;
            err_q        <= err_d;
            smf_q        <= smf_d;
            ebit_q       <= ebit_d;
            lost_q       <= lost_d;
            err_cnt_q    <= err_cnt_d;
            ebit_cnt_q   <= ebit_cnt_d;
        end
    end

    assign out_crc_ok   = ok_q;
    assign out_crc_err  = err_q;
    assign out_smf      = smf_q;
    assign out_ebit_err = ebit_q;
    assign out_crc_lost = lost_q;
    assign out_err_cnt  = err_cnt_q;
    assign out_ebit_cnt = ebit_cnt_q;

endmodule

// File: tb/tb_e1_crc4_rx_ctrl.sv
// Scoreboard bench for e1_crc4_rx_ctrl: SMF driver queues expected pulses, a negedge
// monitor pops and checks them when the DUT pulses.
module tb_e1_crc4_rx_ctrl;

    localparam int CNT_W      = 4;
    localparam int WIN_SMF    = 10;
    localparam int WIN_THRESH = 9;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_bit = 1'b0, in_valid = 1'b0, in_mf_sync = 1'b0, cnt_clr = 1'b0;
    logic [3:0] in_frame = 4'd0;
    logic [4:0] in_ts = 5'd0;
    logic [2:0] in_bitpos = 3'd0;
    logic out_crc_ok, out_crc_err, out_smf, out_ebit_err, out_crc_lost;
    logic [CNT_W-1:0] out_err_cnt, out_ebit_cnt;

    typedef struct { int cyc; bit err; bit smf; bit lost; int cnt; } crc_exp_t;
    typedef struct { int cyc; int cnt; } ebit_exp_t;

    crc_exp_t  crc_exp_q[$];
    ebit_exp_t ebit_exp_q[$];
    crc_exp_t  ce;
    ebit_exp_t ee;
    int passed = 0, total = 0, cyc = 0;
    int exp_err_cnt = 0, exp_ebit_cnt = 0;
    logic [3:0]  tx_c = 4'h0;
    logic [15:0] lfsr = 16'hACE1;
    bit msg_q[$];

    e1_crc4_rx_ctrl #(
        .WIN_SMF    (WIN_SMF),
        .WIN_THRESH (WIN_THRESH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_bit       (in_bit),
        .in_valid     (in_valid),
        .in_frame     (in_frame),
        .in_ts        (in_ts),
        .in_bitpos    (in_bitpos),
        .in_mf_sync   (in_mf_sync),
        .cnt_clr      (cnt_clr),
        .out_crc_ok   (out_crc_ok),
        .out_crc_err  (out_crc_err),
        .out_smf      (out_smf),
        .out_ebit_err (out_ebit_err),
        .out_crc_lost (out_crc_lost),
        .out_err_cnt  (out_err_cnt),
        .out_ebit_cnt (out_ebit_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    endtask

    // Polynomial long division of M(x)*x^4 by x^4+x+1.
    function automatic logic [3:0] crc_div();
        logic [4:0] r;
        r = 5'd0;
        foreach (msg_q[i]) begin
            r = {r[3:0], msg_q[i]};
            if (r[4]) r = r ^ 5'b10011;
        end
        for (int k = 0; k < 4; k++) begin
            r = {r[3:0], 1'b0};
            if (r[4]) r = r ^ 5'b10011;
        end
        return r[3:0];
    endfunction

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic drive(input logic v, input logic [3:0] fr, input logic [4:0] ts,
                         input logic [2:0] bp, input logic b);
        in_valid = v; in_frame = fr; in_ts = ts; in_bitpos = bp; in_bit = b;
        @(posedge clk); #1;
    endtask

    // Each frame carries TS0, TS1 and TS31, plus one invalid cycle with EOS-like fields.
    task automatic send_smf(input bit sel, input logic [3:0] c_xor, input bit e1, input bit e2,
                            input bit exp_cmp, input bit exp_err, input bit exp_lost,
                            input int sync_frames, input int clr_frame, input int n_frames);
        logic [3:0] cbits;
        logic [3:0] fr;
        logic       b;
        bit         is_c;
        int         ts;
        cbits = tx_c ^ c_xor;
        msg_q.delete();
        for (int f = 0; f < n_frames; f++) begin
            fr = {sel, 3'(f)};
            in_mf_sync = (f < sync_frames);
            for (int t = 0; t < 3; t++) begin
                for (int bp = 0; bp < 8; bp++) begin
                    ts = (t == 2) ? 31 : t;
                    lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                    b = lfsr[0];
                    is_c = 1'b0;
                    cnt_clr = 1'b0;
                    if (ts == 0 && bp == 0) begin
                        if (f % 2 == 0) begin
                            b = cbits[3 - f / 2];
                            is_c = 1'b1;
                        end else if (fr == 4'd13) b = e1;
                        else if (fr == 4'd15) b = e2;
                        else b = 1'b1;
                        if (f == clr_frame) begin
                            cnt_clr = 1'b1;
                            exp_err_cnt = 0;
                            exp_ebit_cnt = 0;
                        end
                        if ((fr == 4'd13 || fr == 4'd15) && !b) begin
                            exp_ebit_cnt = sat(exp_ebit_cnt + 1);
                            ebit_exp_q.push_back('{cyc + 1, exp_ebit_cnt});
                        end
                    end
                    if (f == 7 && ts == 31 && bp == 7 && exp_cmp) begin
                        if (exp_err) exp_err_cnt = sat(exp_err_cnt + 1);
                        crc_exp_q.push_back('{cyc + 2, exp_err, sel, exp_lost, exp_err_cnt});
                    end
                    msg_q.push_back(is_c ? 1'b0 : b);
                    drive(1'b1, fr, 5'(ts), 3'(bp), b);
                    if (ts == 1 && bp == 7) drive(1'b0, {sel, 3'b111}, 5'd31, 3'd7, lfsr[1]);
                end
            end
        end
        cnt_clr = 1'b0;
        if (n_frames == 8) tx_c = crc_div();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_crc_ok || out_crc_err || out_crc_lost) begin
                $display("crc event cyc=%0d ok=%0b err=%0b smf=%0b lost=%0b err_cnt=%0d",
                         cyc, out_crc_ok, out_crc_err, out_smf, out_crc_lost, out_err_cnt);
                if (crc_exp_q.size() == 0) begin
                    chk("crc_spurious", 1, 0);
                end else begin
                    ce = crc_exp_q.pop_front();
                    chk("crc_cycle", cyc, ce.cyc);
                    chk("crc_ok", int'(out_crc_ok), int'(!ce.err));
                    chk("crc_err", int'(out_crc_err), int'(ce.err));
                    chk("crc_smf", int'(out_smf), int'(ce.smf));
                    chk("crc_lost", int'(out_crc_lost), int'(ce.lost));
                    chk("err_cnt", int'(out_err_cnt), ce.cnt);
                end
            end
            if (out_ebit_err) begin
                $display("ebit event cyc=%0d ebit_cnt=%0d", cyc, out_ebit_cnt);
                if (ebit_exp_q.size() == 0) begin
                    chk("ebit_spurious", 1, 0);
                end else begin
                    ee = ebit_exp_q.pop_front();
                    chk("ebit_cycle", cyc, ee.cyc);
                    chk("ebit_cnt", int'(out_ebit_cnt), ee.cnt);
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ok"},       int'(out_crc_ok), 0);
        chk({tag, "_err"},      int'(out_crc_err), 0);
        chk({tag, "_smf"},      int'(out_smf), 0);
        chk({tag, "_ebit"},     int'(out_ebit_err), 0);
        chk({tag, "_lost"},     int'(out_crc_lost), 0);
        chk({tag, "_err_cnt"},  int'(out_err_cnt), 0);
        chk({tag, "_ebit_cnt"}, int'(out_ebit_cnt), 0);
    endtask

    initial begin
        bit e;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_all_zero("reset");
        repeat (2) drive(1'b0, 4'd0, 5'd0, 3'd0, 1'b0);

        send_smf(1'b0, 4'h0, 1, 1, 0, 0, 0, 8, -1, 8);   // SMF1: FIRST, no compare
        send_smf(1'b1, 4'h0, 1, 1, 1, 0, 0, 8, -1, 8);   // SMF2
        send_smf(1'b0, 4'h0, 1, 1, 1, 0, 0, 8, -1, 8);   // SMF3
        send_smf(1'b1, 4'h0, 1, 1, 1, 0, 0, 8, -1, 8);   // SMF4
        send_smf(1'b0, 4'b0100, 1, 1, 1, 1, 0, 8, -1, 8); // SMF5: C2 flipped
        send_smf(1'b1, 4'h0, 0, 1, 1, 0, 0, 8, -1, 8);   // SMF6: E1=0
        send_smf(1'b0, 4'h0, 1, 1, 1, 0, 0, 8, -1, 8);   // SMF7
        send_smf(1'b1, 4'h0, 0, 0, 1, 0, 0, 8, 7, 8);    // SMF8: clr with E2 error
        send_smf(1'b0, 4'h0, 1, 1, 0, 0, 0, 4, -1, 8);   // SMF9: sync lost mid-SMF
        send_smf(1'b1, 4'h0, 1, 1, 0, 0, 0, 8, -1, 8);   // SMF10: resync, FIRST
        for (int k = 11; k <= 30; k++) begin
            e = (k <= 19) || (k >= 21 && k <= 28);
            send_smf(k % 2 == 0, e ? 4'b0001 : 4'h0, 1, 1, 1, e, k == 20, 8, -1, 8);
        end
        send_smf(1'b0, 4'h0, 1, 1, 0, 0, 0, 8, -1, 4);   // partial SMF31

        chk("crc_queue_drained", crc_exp_q.size(), 0);
        chk("ebit_queue_drained", ebit_exp_q.size(), 0);
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1);
    end

endmodule
